sht40_convert: RTL and testbench

Downstream conversion stage for the SHT40 datapath. Watches the CRC-checked raw temperature and humidity words and their ready flags from `i2c_sht40`. Converts each new word to signed fixed-point hundredths of °C or %RH using a serial shift-add multiplier. Presents the results with one-cycle valid strobes to display and UART consumers.

---
 rtl/sht40_pkg.sv | 33 +++
 rtl/sht40_convert_if.sv | 28 ++
 rtl/sht40_serial_mul.sv | 57 +++++
 rtl/sht40_convert.sv | 163 ++++++++++++++++
 tb/tb_sht40_convert.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/sht40_pkg.sv
// sht40_pkg: shared types and constants for the SHT40 conversion stage.
//   state_t       - 2-bit conversion FSM state
//   DEF_*         - default scale/offset constants in hundredths
//   RH_MAX_CENTI  - upper humidity crop limit (100.00 %RH)
//   MUL_ITERS     - number of shift-add iterations (one per raw bit)
//   clamp_rh()    - crops a signed humidity result to 0..RH_MAX_CENTI
package sht40_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_MUL    = 2'd2,
    ST_FINISH = 2'd3
  } state_t;

  localparam int DEF_T_SCALE   = 17500;
  localparam int DEF_T_OFFSET  = 4500;
  localparam int DEF_RH_SCALE  = 12500;
  localparam int DEF_RH_OFFSET = 600;

  localparam int RH_MAX_CENTI  = 10000;
  localparam int MUL_ITERS     = 16;

  function automatic logic [15:0] clamp_rh(input logic signed [16:0] v);
    if (v < 0)
      return 16'd0;
    else if (v > 17'sd10000)
      return 16'(RH_MAX_CENTI);
    else
      return v[15:0];
  endfunction

endpackage

// File: rtl/sht40_convert_if.sv
// sht40_convert_if: raw-word inputs and converted-result outputs of the
// SHT40 conversion stage.
//   master - the surrounding system: drives raw words/ready flags, reads results
//   slave  - sht40_convert itself
interface sht40_convert_if;

  logic [15:0] Temperature_In;
  logic [15:0] Humidity_In;
  logic        Temp_Ready_In;
  logic        RH_Ready_In;
  logic [15:0] Temp_Centi;
  logic [15:0] RH_Centi;
  logic        Temp_Valid;
  logic        RH_Valid;
  logic        Busy;
  logic        Overrun;

  modport master (
    output Temperature_In, Humidity_In, Temp_Ready_In, RH_Ready_In,
    input  Temp_Centi, RH_Centi, Temp_Valid, RH_Valid, Busy, Overrun
  );

  modport slave (
    input  Temperature_In, Humidity_In, Temp_Ready_In, RH_Ready_In,
    output Temp_Centi, RH_Centi, Temp_Valid, RH_Valid, Busy, Overrun
  );

endinterface

// File: rtl/sht40_serial_mul.sv
// sht40_serial_mul: 16x15 serial shift-add multiplier, LSB first.
//   clk, rst_n - clock, synchronous active-low reset
//   start      - load operands and clear the accumulator
//   mcand      - 15-bit multiplicand (scale constant)
//   mplier     - 16-bit multiplier (raw sensor word)
//   product    - 31-bit accumulator / final product
//   done       - high during the last iteration; product is final one cycle later
module sht40_serial_mul
  import sht40_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [14:0] mcand,
  input  logic [15:0] mplier,
  output logic [30:0] product,
  output logic        done
);

  localparam logic [4:0] ITERS = 5'(MUL_ITERS);

  logic [30:0] acc;
  logic [30:0] addend;
  logic [15:0] bits;
  logic [4:0]  cnt;
  logic        run;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc    <= '0;
      addend <= '0;
      bits   <= '0;
      cnt    <= '0;
      run    <= 1'b0;
    end else if (start) begin
      acc    <= '0;
      addend <= {16'd0, mcand};
      bits   <= mplier;
      cnt    <= ITERS;
      run    <= 1'b1;
    end else if (run) begin
      if (bits[0])
        acc <= acc + addend;
      addend <= {addend[29:0], 1'b0};
      bits   <= {1'b0, bits[15:1]};
      cnt    <= cnt - 5'd1;
      if (cnt == 5'd1)
        run <= 1'b0;
    end
  end

  assign product = acc;
  // Flag the final iteration so the controller can step to FINISH on the
  // same edge the last partial product lands.
  assign done    = run && (cnt == 5'd1);

endmodule

// File: rtl/sht40_convert.sv
// sht40_convert: converts raw SHT40 temperature/humidity words to signed
// hundredths of degC / %RH: ((raw * SCALE) >> 16) - OFFSET.
//   clk, rst_n - clock, synchronous active-low reset
//   bus        - sht40_convert_if.slave: raw words + ready levels in,
//                results, one-cycle valids, Busy and sticky Overrun out
// Build option: define SHT40_CONVERT_CLAMP_EN to crop humidity to 0..10000.
//
// state     | meaning
// ST_IDLE   | wait for a pending channel, temperature first
// ST_LOAD   | start the multiplier with the selected scale and raw word
// ST_MUL    | 16 shift-add iterations in progress
// ST_FINISH | subtract offset, write result, pulse valid
module sht40_convert
  import sht40_pkg::*;
#(
  parameter int T_SCALE   = DEF_T_SCALE,
  parameter int T_OFFSET  = DEF_T_OFFSET,
  parameter int RH_SCALE  = DEF_RH_SCALE,
  parameter int RH_OFFSET = DEF_RH_OFFSET
) (
  input  logic             clk,
  input  logic             rst_n,
  sht40_convert_if.slave   bus
);

  localparam logic [14:0] T_SCALE15  = 15'(T_SCALE);
  localparam logic [14:0] RH_SCALE15 = 15'(RH_SCALE);
  localparam logic [15:0] T_OFF16    = 16'(T_OFFSET);
  localparam logic [15:0] RH_OFF16   = 16'(RH_OFFSET);

  state_t      state;
  logic        sel_rh;
  logic        start;
  logic        pend_t, pend_rh;
  logic        prev_t, prev_rh;
  logic        edge_en;
  logic [15:0] hold_t, hold_rh;
  logic [15:0] temp_centi, rh_centi;
  logic        temp_valid, rh_valid;
  logic        busy, overrun;

  logic        rise_t, rise_rh;
  logic [30:0] product;
  logic        mul_done;
  logic [15:0] prod_hi;
  logic [15:0] temp_res, rh_res;
  logic        unused_bits;

  // edge_en holds off detection for one cycle so a level already high at
  // reset release is absorbed into prev_* rather than seen as an edge.
  assign rise_t  = edge_en && bus.Temp_Ready_In && !prev_t;
  assign rise_rh = edge_en && bus.RH_Ready_In   && !prev_rh;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prev_t  <= 1'b0;
      prev_rh <= 1'b0;
      edge_en <= 1'b0;
      hold_t  <= '0;
      hold_rh <= '0;
    end else begin
      prev_t  <= bus.Temp_Ready_In;
      prev_rh <= bus.RH_Ready_In;
      edge_en <= 1'b1;
      if (rise_t)
        hold_t <= bus.Temperature_In;
      if (rise_rh)
        hold_rh <= bus.Humidity_In;
    end
  end

  sht40_serial_mul u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .mcand   (sel_rh ? RH_SCALE15 : T_SCALE15),
    .mplier  (sel_rh ? hold_rh : hold_t),
    .product (product),
    .done    (mul_done)
  );

  // The fractional half of the product is dropped by the >>16.
  assign unused_bits = ^product[15:0];
  assign prod_hi     = {1'b0, product[30:16]};
  assign temp_res    = prod_hi - T_OFF16;

`ifdef SHT40_CONVERT_CLAMP_EN
  logic signed [16:0] rh_diff;
  assign rh_diff = signed'({1'b0, prod_hi} - {1'b0, RH_OFF16});
  assign rh_res  = clamp_rh(rh_diff);
`else
  assign rh_res  = prod_hi - RH_OFF16;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      sel_rh     <= 1'b0;
      start      <= 1'b0;
      pend_t     <= 1'b0;
      pend_rh    <= 1'b0;
      temp_centi <= '0;
      rh_centi   <= '0;
      temp_valid <= 1'b0;
      rh_valid   <= 1'b0;
      busy       <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      temp_valid <= 1'b0;
      rh_valid   <= 1'b0;
      start      <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (pend_t) begin
            sel_rh <= 1'b0;
            pend_t <= 1'b0;
            start  <= 1'b1;
            busy   <= 1'b1;
            state  <= ST_LOAD;
          end else if (pend_rh) begin
            sel_rh  <= 1'b1;
            pend_rh <= 1'b0;
            start   <= 1'b1;
            busy    <= 1'b1;
            state   <= ST_LOAD;
          end
        end
        ST_LOAD: state <= ST_MUL;
        ST_MUL: begin
          if (mul_done)
            state <= ST_FINISH;
        end
        ST_FINISH: begin
          if (sel_rh) begin
            rh_centi <= rh_res;
            rh_valid <= 1'b1;
          end else begin
            temp_centi <= temp_res;
            temp_valid <= 1'b1;
          end
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
      // A new edge re-arms its channel even if IDLE consumed it this cycle.
      if (rise_t)
        pend_t <= 1'b1;
      if (rise_rh)
        pend_rh <= 1'b1;
      if ((rise_t && pend_t) || (rise_rh && pend_rh))
        overrun <= 1'b1;
    end
  end

  assign bus.Temp_Centi = temp_centi;
  assign bus.RH_Centi   = rh_centi;
  assign bus.Temp_Valid = temp_valid;
  assign bus.RH_Valid   = rh_valid;
  assign bus.Busy       = busy;
  assign bus.Overrun    = overrun;

endmodule

// File: tb/tb_sht40_convert.sv
// tb_sht40_convert: directed bench for sht40_convert with a cycle-level
// behavioural model checked every cycle, plus literal result/latency checks.
module tb_sht40_convert;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  sht40_convert_if bus();

  sht40_convert #(
    .T_SCALE   (17500),
    .T_OFFSET  (4500),
    .RH_SCALE  (12500),
    .RH_OFFSET (600)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

`ifdef SHT40_CONVERT_CLAMP_EN
  localparam bit CLAMP = 1'b1;
`else
  localparam bit CLAMP = 1'b0;
`endif
  localparam logic [15:0] RH_FFFF_EXP = CLAMP ? 16'd10000 : 16'd11899;
  localparam logic [15:0] RH_0000_EXP = CLAMP ? 16'd0     : 16'hFDA8;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [35:0] got, input logic [35:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", nm, got, want);
    end
  endtask

  // Reference conversion in plain integer arithmetic.
  function automatic logic [15:0] conv(input logic [15:0] raw, input bit is_rh);
    longint p;
    longint r;
    p = longint'(raw) * (is_rh ? 64'sd12500 : 64'sd17500);
    r = p / 65536 - (is_rh ? 64'sd600 : 64'sd4500);
    if (is_rh && CLAMP) begin
      if (r < 0)     r = 0;
      if (r > 10000) r = 10000;
    end
    return 16'(r);
  endfunction

  // Model: pending word per channel, one job at a time; a job picked in
  // cycle k shows its result/valid in cycle k+19 and Busy in k+1..k+18.
  int          cyc = 0;
  bit          live = 0;
  bit          m_pt, m_prh, m_prev_t, m_prev_rh, m_en, m_act, m_ch, m_ovr;
  logic [15:0] m_wt, m_wrh, m_val, m_tc, m_rc;
  int          m_end;
  logic [35:0] exp_v, got_v;

  always @(negedge clk) begin
    cyc++;
    if (live) begin
      if (m_act && cyc == m_end) begin
        if (m_ch) m_rc = m_val;
        else      m_tc = m_val;
      end
      exp_v = {m_tc, m_rc,
               (m_act && cyc == m_end && !m_ch),
               (m_act && cyc == m_end && m_ch),
               (m_act && cyc >= m_end - 18 && cyc < m_end),
               m_ovr};
      got_v = {bus.Temp_Centi, bus.RH_Centi, bus.Temp_Valid, bus.RH_Valid,
               bus.Busy, bus.Overrun};
      chk($sformatf("cycle%0d", cyc), got_v, exp_v);
    end
    if (!rst_n) begin
      m_pt = 0; m_prh = 0; m_prev_t = 0; m_prev_rh = 0; m_en = 0;
      m_act = 0; m_ch = 0; m_ovr = 0; m_tc = '0; m_rc = '0;
      m_wt = '0; m_wrh = '0; m_val = '0; m_end = 0;
      live = 1;
    end else if (live) begin
      if (m_act && cyc == m_end) m_act = 0;
      if (!m_act) begin
        if (m_pt) begin
          m_act = 1; m_ch = 0; m_val = conv(m_wt, 0); m_end = cyc + 19; m_pt = 0;
        end else if (m_prh) begin
          m_act = 1; m_ch = 1; m_val = conv(m_wrh, 1); m_end = cyc + 19; m_prh = 0;
        end
      end
      if (m_en && bus.Temp_Ready_In && !m_prev_t) begin
        if (m_pt) m_ovr = 1;
        m_pt = 1; m_wt = bus.Temperature_In;
      end
      if (m_en && bus.RH_Ready_In && !m_prev_rh) begin
        if (m_prh) m_ovr = 1;
        m_prh = 1; m_wrh = bus.Humidity_In;
      end
      m_prev_t  = bus.Temp_Ready_In;
      m_prev_rh = bus.RH_Ready_In;
      m_en      = 1;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input bit rh, output int lat);
    lat = -1;
    for (int i = 1; i <= 60; i++) begin
      @(posedge clk);
      #1;
      if (rh ? bus.RH_Valid : bus.Temp_Valid) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic count_window(input int n, output int nv);
    nv = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (bus.Temp_Valid || bus.RH_Valid) nv++;
    end
  endtask

  task automatic conv_one(input bit rh, input logic [15:0] w, input logic [15:0] want,
                          input string nm);
    int lat;
    if (rh) begin bus.Humidity_In = w;    bus.RH_Ready_In = 1'b1;   end
    else    begin bus.Temperature_In = w; bus.Temp_Ready_In = 1'b1; end
    wait_valid(rh, lat);
    chk({nm, "_lat"}, 36'(lat), 36'd20);
    chk({nm, "_val"}, 36'(rh ? bus.RH_Centi : bus.Temp_Centi), 36'(want));
    bus.Temp_Ready_In = 1'b0;
    bus.RH_Ready_In   = 1'b0;
    tick(2);
  endtask

  initial begin
    int lat;
    int nv;
    rst_n = 1'b0;
    bus.Temperature_In = '0;
    bus.Humidity_In    = '0;
    bus.Temp_Ready_In  = 1'b0;
    bus.RH_Ready_In    = 1'b0;
    tick(3);
    rst_n = 1'b1;
    chk("reset_state", {bus.Temp_Centi, bus.RH_Centi, bus.Temp_Valid, bus.RH_Valid,
                        bus.Busy, bus.Overrun}, 36'd0);
    tick(3);

    conv_one(0, 16'h6666, 16'd2499,  "t_6666");
    conv_one(0, 16'h0000, 16'hEE6C,  "t_0000");
    conv_one(0, 16'hFFFF, 16'd12999, "t_ffff");
    conv_one(1, 16'h8000, 16'd5650,  "rh_8000");
    conv_one(1, 16'hFFFF, RH_FFFF_EXP, "rh_ffff");
    conv_one(1, 16'h0000, RH_0000_EXP, "rh_0000");

    // simultaneous edges: temperature first, humidity 19 cycles later
    bus.Temperature_In = 16'h6666;
    bus.Humidity_In    = 16'h8000;
    bus.Temp_Ready_In  = 1'b1;
    bus.RH_Ready_In    = 1'b1;
    wait_valid(0, lat);
    chk("both_t_lat", 36'(lat), 36'd20);
    chk("both_t_val", 36'(bus.Temp_Centi), 36'd2499);
    wait_valid(1, lat);
    chk("both_rh_lat", 36'(lat), 36'd19);
    chk("both_rh_val", 36'(bus.RH_Centi), 36'd5650);
    chk("both_ovr", 36'(bus.Overrun), 36'd0);
    bus.Temp_Ready_In = 1'b0;
    bus.RH_Ready_In   = 1'b0;
    tick(2);

    // humidity word replaced while temperature converts
    bus.Temperature_In = 16'h0000;
    bus.Temp_Ready_In  = 1'b1;
    tick(3);
    bus.Humidity_In = 16'h1111;
    bus.RH_Ready_In = 1'b1;
    tick(2);
    bus.RH_Ready_In = 1'b0;
    tick(2);
    bus.Humidity_In = 16'h8000;
    bus.RH_Ready_In = 1'b1;
    wait_valid(1, lat);
    chk("ovr_rh_lat", 36'(lat), 36'd32);
    chk("ovr_rh_val", 36'(bus.RH_Centi), 36'd5650);
    chk("ovr_flag", 36'(bus.Overrun), 36'd1);
    chk("ovr_t_held", 36'(bus.Temp_Centi), 36'hEE6C);
    bus.Temp_Ready_In = 1'b0;
    bus.RH_Ready_In   = 1'b0;
    tick(2);

    // reset in the 10th MUL cycle
    bus.Temperature_In = 16'hFFFF;
    bus.Temp_Ready_In  = 1'b1;
    tick(12);
    chk("pre_rst_busy", 36'(bus.Busy), 36'd1);
    rst_n = 1'b0;
    bus.Temp_Ready_In = 1'b0;
    bus.Humidity_In   = 16'h8000;
    bus.RH_Ready_In   = 1'b1;
    tick(1);
    chk("mid_rst_state", {bus.Temp_Centi, bus.RH_Centi, bus.Temp_Valid, bus.RH_Valid,
                          bus.Busy, bus.Overrun}, 36'd0);
    tick(1);
    rst_n = 1'b1;
    count_window(25, nv);
    chk("no_valid_after_rst", 36'(nv), 36'd0);
    bus.RH_Ready_In = 1'b0;
    tick(2);
    conv_one(0, 16'h6666, 16'd2499, "post_rst");
    tick(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: run did not complete");
    $fatal(1, "timeout");
  end

endmodule
